// File: rtl/multi_timer.sv
// rtl/multi_timer.sv - N-channel down-counting timer with one-shot, periodic and PWM modes
// Each channel latches its config at start; compare is re-latched at every reload.
module multi_timer #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32,
  parameter int PSC_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [2*NUM_CH-1:0]     mode,
  input  logic [PSC_W*NUM_CH-1:0] prescaler,
  input  logic [CNT_W*NUM_CH-1:0] reload_val,
  input  logic [CNT_W*NUM_CH-1:0] compare_val,
  input  logic [NUM_CH-1:0]       start,
  input  logic [NUM_CH-1:0]       stop,
  input  logic [NUM_CH-1:0]       irq_en,
  input  logic [NUM_CH-1:0]       irq_clr,
  output logic [NUM_CH-1:0]       timeout,
  output logic [NUM_CH-1:0]       pwm_out,
  output logic [NUM_CH-1:0]       busy,
  output logic [CNT_W*NUM_CH-1:0] current_count,
  output logic [NUM_CH-1:0]       irq_status,
  output logic                    irq
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

  localparam logic [1:0] MODE_PER = 2'b01;
  localparam logic [1:0] MODE_PWM = 2'b10;

  state_e           state_q   [NUM_CH];
  state_e           state_d   [NUM_CH];
  logic [CNT_W-1:0] count_q   [NUM_CH];
  logic [CNT_W-1:0] count_d   [NUM_CH];
  logic [CNT_W-1:0] reload_q  [NUM_CH];
  logic [CNT_W-1:0] reload_d  [NUM_CH];
  logic [CNT_W-1:0] cmp_q     [NUM_CH];
  logic [CNT_W-1:0] cmp_d     [NUM_CH];
  logic [PSC_W-1:0] psc_q     [NUM_CH];
  logic [PSC_W-1:0] psc_d     [NUM_CH];
  logic [PSC_W-1:0] psc_lat_q [NUM_CH];
  logic [PSC_W-1:0] psc_lat_d [NUM_CH];
  logic [1:0]       mode_q    [NUM_CH];
  logic [1:0]       mode_d    [NUM_CH];
  logic [NUM_CH-1:0] timeout_q, timeout_d;
  logic [NUM_CH-1:0] pwm_q, pwm_d;
  logic [NUM_CH-1:0] status_q, status_d;
  logic              irq_q, irq_d;

  always_comb begin
    logic tick;
    irq_d     = |(status_q & irq_en);
    timeout_d = '0;
    pwm_d     = '0;
    status_d  = '0;
    tick      = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      state_d[i]   = state_q[i];
      count_d[i]   = count_q[i];
      reload_d[i]  = reload_q[i];
      cmp_d[i]     = cmp_q[i];
      psc_d[i]     = psc_q[i];
      psc_lat_d[i] = psc_lat_q[i];
      mode_d[i]    = mode_q[i];

      tick = (state_q[i] == RUN) && (psc_q[i] == psc_lat_q[i]);
      if (state_q[i] == RUN) begin
        psc_d[i] = tick ? '0 : psc_q[i] + PSC_W'(1);
      end
      if (tick) begin
        if (count_q[i] != '0) begin
          count_d[i] = count_q[i] - CNT_W'(1);
        end else begin
          timeout_d[i] = 1'b1;
          if (mode_q[i] == MODE_PER || mode_q[i] == MODE_PWM) begin
            count_d[i] = reload_q[i];
            cmp_d[i]   = compare_val[i*CNT_W +: CNT_W];
          end else begin
            state_d[i] = IDLE;
          end
        end
      end
      // stop freezes the count even on a tick; start overrides everything
      if (stop[i]) begin
        state_d[i] = IDLE;
        count_d[i] = count_q[i];
      end
      if (start[i]) begin
        mode_d[i]    = mode[2*i +: 2];
        psc_lat_d[i] = prescaler[i*PSC_W +: PSC_W];
        reload_d[i]  = reload_val[i*CNT_W +: CNT_W];
        cmp_d[i]     = compare_val[i*CNT_W +: CNT_W];
        count_d[i]   = reload_val[i*CNT_W +: CNT_W];
        psc_d[i]     = '0;
        state_d[i]   = RUN;
      end

      pwm_d[i] = (state_q[i] == RUN) && (state_d[i] == RUN) &&
                 (mode_q[i] == MODE_PWM) && (count_q[i] < cmp_q[i]);
      // a clear is ignored while a fresh expiry is being reported
      status_d[i] = timeout_d[i] | (status_q[i] & ~(irq_clr[i] & ~timeout_q[i]));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i]   <= IDLE;
        count_q[i]   <= '0;
        reload_q[i]  <= '0;
        cmp_q[i]     <= '0;
        psc_q[i]     <= '0;
        psc_lat_q[i] <= '0;
        mode_q[i]    <= '0;
      end
      timeout_q <= '0;
      pwm_q     <= '0;
      status_q  <= '0;
      irq_q     <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i]   <= state_d[i];
        count_q[i]   <= count_d[i];
        reload_q[i]  <= reload_d[i];
        cmp_q[i]     <= cmp_d[i];
        psc_q[i]     <= psc_d[i];
        psc_lat_q[i] <= psc_lat_d[i];
        mode_q[i]    <= mode_d[i];
      end
      timeout_q <= timeout_d;
      pwm_q     <= pwm_d;
      status_q  <= status_d;
      irq_q     <= irq_d;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      busy[i]                          = (state_q[i] == RUN);
      current_count[i*CNT_W +: CNT_W] = count_q[i];
    end
  end

  assign timeout    = timeout_q;
  assign pwm_out    = pwm_q;
  assign irq_status = status_q;
  assign irq        = irq_q;

endmodule

// File: tb/tb_multi_timer.sv
// tb/tb_multi_timer.sv - directed and random checks of multi_timer against an elapsed-time model
module tb_multi_timer;
  localparam int N  = 4;
  localparam int CW = 8;
  localparam int PW = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [2*N-1:0]  mode = '0;
  logic [PW*N-1:0] prescaler = '0;
  logic [CW*N-1:0] reload_val = '0;
  logic [CW*N-1:0] compare_val = '0;
  logic [N-1:0]    start = '0, stop = '0, irq_en = '0, irq_clr = '0;
  logic [N-1:0]    timeout, pwm_out, busy, irq_status;
  logic [CW*N-1:0] current_count;
  logic            irq;

  always #5 clk = ~clk;

  multi_timer #(.NUM_CH(N), .CNT_W(CW), .PSC_W(PW)) dut (
    .clk(clk), .rst(rst), .mode(mode), .prescaler(prescaler),
    .reload_val(reload_val), .compare_val(compare_val),
    .start(start), .stop(stop), .irq_en(irq_en), .irq_clr(irq_clr),
    .timeout(timeout), .pwm_out(pwm_out), .busy(busy),
    .current_count(current_count), .irq_status(irq_status), .irq(irq)
  );

  int checks = 0;
  int errors = 0;

  // model: a running channel is described by cycles elapsed since it entered RUN
  bit       m_run [N];
  int       m_e   [N];
  int       m_rl  [N];
  int       m_ps  [N];
  int       m_cmp [N];
  int       m_hold[N];
  bit [1:0] m_md  [N];
  bit [N-1:0] m_to = '0, m_pw = '0, m_st = '0;
  bit       m_irq = 1'b0;

  function automatic int mper(int i);
    return (m_rl[i] + 1) * (m_ps[i] + 1);
  endfunction

  function automatic bit mrel(int i);
    return (m_md[i] == 2'd1) || (m_md[i] == 2'd2);
  endfunction

  function automatic int mcnt(int i);
    if (!m_run[i]) return m_hold[i];
    if (mrel(i)) return m_rl[i] - (m_e[i] % mper(i)) / (m_ps[i] + 1);
    return m_rl[i] - m_e[i] / (m_ps[i] + 1);
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    bit [N-1:0] nto, nst, npw;
    bit nirq, x, nrun;
    int c;
    nirq = |(m_st & irq_en);
    for (int i = 0; i < N; i++) begin
      c = mcnt(i);
      x = m_run[i] && ((m_e[i] % mper(i)) == mper(i) - 1);
      nto[i] = x;
      nst[i] = x | (m_st[i] & ~(irq_clr[i] & ~m_to[i]));
      if (start[i]) nrun = 1'b1;
      else if (stop[i]) nrun = 1'b0;
      else if (x && !mrel(i)) nrun = 1'b0;
      else nrun = m_run[i];
      npw[i] = m_run[i] && nrun && (m_md[i] == 2'd2) && (c < m_cmp[i]);
      if (start[i]) begin
        m_run[i] = 1'b1;
        m_e[i]   = 0;
        m_md[i]  = mode[2*i +: 2];
        m_ps[i]  = int'(prescaler[PW*i +: PW]);
        m_rl[i]  = int'(reload_val[CW*i +: CW]);
        m_cmp[i] = int'(compare_val[CW*i +: CW]);
      end else if (stop[i]) begin
        if (m_run[i]) m_hold[i] = c;
        m_run[i] = 1'b0;
      end else if (m_run[i]) begin
        if (x && !mrel(i)) begin
          m_run[i]  = 1'b0;
          m_hold[i] = 0;
        end else begin
          m_e[i]++;
          if (x) m_cmp[i] = int'(compare_val[CW*i +: CW]);
        end
      end
    end
    m_to = nto; m_st = nst; m_pw = npw; m_irq = nirq;
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        m_run[i] = 1'b0; m_e[i] = 0; m_rl[i] = 0; m_ps[i] = 0;
        m_cmp[i] = 0; m_hold[i] = 0; m_md[i] = 2'd0;
      end
      m_to = '0; m_st = '0; m_pw = '0; m_irq = 1'b0;
    end
  endtask

  task automatic check_all();
    logic [CW*N-1:0] ec;
    logic [N-1:0] eb;
    for (int i = 0; i < N; i++) begin
      ec[CW*i +: CW] = CW'(mcnt(i));
      eb[i] = m_run[i];
    end
    chk("count", current_count, ec);
    chk("busy", busy, eb);
    chk("timeout", timeout, m_to);
    chk("pwm_out", pwm_out, m_pw);
    chk("irq_status", irq_status, m_st);
    chk("irq", irq, m_irq);
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    check_all();
    start = '0; stop = '0; irq_clr = '0;
  endtask

  task automatic set_cfg(int ch, int md, int ps, int rl, int cmp);
    mode[2*ch +: 2]          = 2'(md);
    prescaler[PW*ch +: PW]   = PW'(ps);
    reload_val[CW*ch +: CW]  = CW'(rl);
    compare_val[CW*ch +: CW] = CW'(cmp);
  endtask

  task automatic wait_to(int ch, int lim);
    int n = 0;
    do begin
      step();
      n++;
    end while (!timeout[ch] && n < lim);
    chk("wait_timeout", timeout[ch], 1'b1);
  endtask

  task automatic count_pwm(int ch, int nsteps, output int hi);
    hi = 0;
    for (int k = 0; k < nsteps; k++) begin
      step();
      if (pwm_out[ch]) hi++;
    end
  endtask

  initial begin
    int hi, pulses;
    int first[N];
    int rls[N];

    // reset
    step(); step();
    chk("rst_count", current_count, '0);
    chk("rst_busy", busy, '0);
    rst = 1'b0;
    step();

    // one-shot ch0: 3,2,1,0 then timeout and idle
    set_cfg(0, 0, 0, 3, 0);
    start[0] = 1'b1;
    step();
    chk("t1_load", current_count[7:0], 8'd3);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t1_count", current_count[7:0], 8'(2 - k));
      chk("t1_no_to", timeout[0], 1'b0);
    end
    step();
    chk("t1_timeout", timeout[0], 1'b1);
    chk("t1_idle", busy[0], 1'b0);
    step();
    chk("t1_pulse_end", timeout[0], 1'b0);
    chk("t1_hold0", current_count[7:0], 8'd0);

    // periodic ch1: reload 4, prescaler 2 -> period 15
    set_cfg(1, 1, 2, 4, 0);
    start[1] = 1'b1;
    step();
    pulses = 0;
    for (int k = 0; k < 75; k++) begin
      step();
      if (timeout[1]) pulses++;
      if (k == 13) chk("t2_first_pulse", timeout[1], 1'b0);
      if (k == 14) chk("t2_first_pulse", timeout[1], 1'b1);
    end
    chk("t2_pulses", pulses, 5);
    chk("t2_sticky", irq_status[1], 1'b1);
    stop[1] = 1'b1;
    step();

    // PWM ch2: shadowed compare updates
    set_cfg(2, 2, 0, 9, 3);
    start[2] = 1'b1;
    step();
    wait_to(2, 20);
    count_pwm(2, 10, hi);
    chk("t3_duty3", hi, 3);
    for (int k = 0; k < 4; k++) step();
    set_cfg(2, 2, 0, 9, 7);
    wait_to(2, 20);
    count_pwm(2, 10, hi);
    chk("t3_duty7", hi, 7);
    set_cfg(2, 2, 0, 9, 0);
    wait_to(2, 20);
    count_pwm(2, 10, hi);
    chk("t3_duty0", hi, 0);
    set_cfg(2, 2, 0, 9, 12);
    wait_to(2, 20);
    count_pwm(2, 10, hi);
    chk("t3_duty_full", hi, 10);
    stop[2] = 1'b1;
    step();

    // ch3: start+stop restarts, stop alone freezes
    set_cfg(3, 2, 0, 20, 25);
    start[3] = 1'b1;
    step();
    for (int k = 0; k < 5; k++) step();
    start[3] = 1'b1; stop[3] = 1'b1;
    step();
    chk("t4_restart", current_count[31:24], 8'd20);
    chk("t4_busy", busy[3], 1'b1);
    step(); step();
    chk("t4_pwm_on", pwm_out[3], 1'b1);
    stop[3] = 1'b1;
    step();
    chk("t4_stopped", busy[3], 1'b0);
    chk("t4_pwm_off", pwm_out[3], 1'b0);
    chk("t4_frozen", current_count[31:24], 8'd18);
    pulses = 0;
    for (int k = 0; k < 30; k++) begin
      step();
      if (timeout[3]) pulses++;
    end
    chk("t4_no_timeout", pulses, 0);
    chk("t4_still_frozen", current_count[31:24], 8'd18);

    // interrupts
    irq_clr = 4'hF;
    step();
    irq_en = 4'b0101;
    set_cfg(0, 0, 0, 2, 0);
    set_cfg(1, 1, 0, 2, 0);
    start = 4'b0011;
    step();
    step(); step(); step();
    chk("t5_status", irq_status[1:0], 2'b11);
    step();
    chk("t5_irq", irq, 1'b1);
    start[0] = 1'b1; irq_clr[0] = 1'b1;
    step();
    chk("t5_cleared", irq_status[0], 1'b0);
    step(); step(); step();
    chk("t5_new_to", timeout[0], 1'b1);
    irq_clr[0] = 1'b1;
    step();
    chk("t5_set_wins", irq_status[0], 1'b1);
    stop[1] = 1'b1;
    step(); step();
    irq_clr = 4'b0011;
    step();
    chk("t5_clear_both", irq_status[1:0], 2'b00);
    chk("t5_irq_lag", irq, 1'b1);
    step();
    chk("t5_irq_low", irq, 1'b0);

    // reset just before ch0 expiry
    set_cfg(0, 0, 0, 5, 0);
    start[0] = 1'b1;
    step();
    for (int k = 0; k < 5; k++) step();
    rst = 1'b1;
    step();
    chk("t6_no_timeout", timeout, '0);
    chk("t6_busy", busy, '0);
    chk("t6_count", current_count, '0);
    chk("t6_status", irq_status, '0);
    chk("t6_irq", irq, 1'b0);
    chk("t6_pwm", pwm_out, '0);
    rst = 1'b0;
    step();

    // all four channels together
    rls = '{3, 5, 7, 9};
    for (int i = 0; i < N; i++) begin
      set_cfg(i, 0, 0, rls[i], 0);
      first[i] = -1;
    end
    start = 4'hF;
    step();
    for (int k = 1; k <= 12; k++) begin
      step();
      for (int i = 0; i < N; i++)
        if (timeout[i] && first[i] < 0) first[i] = k;
    end
    for (int i = 0; i < N; i++) chk("t6_indep", first[i], rls[i] + 1);

    // random traffic against the model
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int i = 0; i < N; i++) begin
        set_cfg(i, int'($urandom_range(3, 0)), int'($urandom_range(3, 0)),
                int'($urandom_range(12, 0)), int'($urandom_range(14, 0)));
        start[i]   = ($urandom_range(15, 0) == 0);
        stop[i]    = ($urandom_range(23, 0) == 0);
        irq_clr[i] = ($urandom_range(7, 0) == 0);
      end
      if ($urandom_range(31, 0) == 0) irq_en = 4'($urandom);
      rst = ($urandom_range(199, 0) == 0);
      step();
    end
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multi_timer.md
Name: multi_timer

Overview:
Parametrised N-channel down-counting timer. It generalises the single-channel timer to NUM_CH independent channels with configurable counter and prescaler widths. Each channel supports one-shot, periodic and PWM modes, with glitch-free compare shadowing at reload. A shared interrupt block holds sticky per-channel status, a per-channel enable and write-1-to-clear. It sits on the peripheral side of the system; configuration comes from a register block, and irq feeds the interrupt controller.

Parameters:
NUM_CH, 4, number of independent timer channels (1..16)
CNT_W, 32, counter / reload / compare width
PSC_W, 16, prescaler width

Ports:
clk  in  1  system clock; all logic rising-edge
rst  in  1  synchronous, active-high reset
mode  in  2*NUM_CH  per-channel mode, ch i at [2i+1:2i]: 00 one-shot, 01 periodic, 10 PWM, 11 treated as 00
prescaler  in  PSC_W*NUM_CH  per-channel divide-minus-one
reload_val  in  CNT_W*NUM_CH  per-channel load value
compare_val  in  CNT_W*NUM_CH  per-channel PWM threshold
start  in  NUM_CH  per-channel 1-cycle start/restart pulse
stop  in  NUM_CH  per-channel 1-cycle stop pulse
irq_en  in  NUM_CH  per-channel interrupt enable
irq_clr  in  NUM_CH  per-channel write-1-to-clear of irq_status
timeout  out  NUM_CH  1-cycle pulse per expiry
pwm_out  out  NUM_CH  registered PWM output
busy  out  NUM_CH  channel in RUN
current_count  out  CNT_W*NUM_CH  live counter value
irq_status  out  NUM_CH  sticky expiry flags
irq  out  1  OR of (irq_status & irq_en)

Behaviour:
- Reset: every output is 0; all channels IDLE; counts and prescale counters 0; latched config 0.
- Per-channel FSM has two states, IDLE and RUN. Channels are fully independent.
- start[i] (any state):
  - Latches mode, prescaler, reload_val and compare_val for that channel.
  - Loads count=reload, clears the prescale counter and enters RUN.
  - These take effect the next cycle. A start while in RUN restarts the channel.
- stop[i] moves the channel to IDLE. Count is held; pwm_out goes to 0 next cycle.
- start[i] and stop[i] in the same cycle: start wins.
- Config inputs are ignored except at start and reload. Changing them mid-run has no effect until the next start or reload.
- Prescale:
  - In RUN, tick=1 when psc_cnt==psc_latched, then psc_cnt returns to 0; otherwise psc_cnt increments.
  - prescaler=0 gives a tick every cycle.
- On a tick in RUN:
  - count!=0: count decrements by 1.
  - count==0: timeout[i] is high the next cycle for exactly 1 cycle.
    - One-shot: the channel goes to IDLE and count stays 0.
    - Periodic or PWM: count reloads from latched reload, and compare is re-latched from compare_val (shadow update).
- Period = (reload+1)*(prescaler+1) cycles. reload=0 in periodic gives a timeout every prescale period.
- No wrap: count never decrements below 0.
- pwm_out[i]:
  - In PWM mode and RUN, it is the registered value of (count < compare_latched), one cycle behind count.
  - In any other mode or state it is 0.
  - compare=0 gives constant 0; compare>reload gives constant 1.
- busy[i] = (state==RUN). It is the state register itself, not a delayed copy.
- irq_status[i]:
  - Set in the same cycle timeout[i] is high.
  - Cleared the cycle after irq_clr[i]=1.
  - Set and clear in the same cycle: set wins.
- irq is registered: irq = |(irq_status & irq_en), one cycle behind irq_status and irq_en.
- Reset asserted mid-run: all state returns to reset values next cycle. No timeout or irq is emitted.
- Arithmetic is unsigned, CNT_W/PSC_W wide, and there is no overflow path.

Test Plan:
1. Ch0 one-shot, reload=3, prescaler=0, start at cycle N -> count 3,2,1,0 on cycles N+1..N+4; timeout[0] high only at N+5; busy[0] falls at N+5; count holds 0.
2. Ch1 periodic, reload=4, prescaler=2 -> timeout[1] every 15 cycles; first pulse 15 cycles after the cycle following start; 5 pulses in 75 cycles; irq_status[1] sticky.
3. Ch2 PWM, reload=9, compare=3, prescaler=0 -> pwm_out[2] high for 3 of every 10 cycles. Change compare_val to 7 mid-period -> new duty of 7/10 starts only after the next reload. compare=0 gives constant 0; compare=12 gives constant 1.
4. Ch3 running, stop and start asserted in the same cycle -> restart (count=reload next cycle). Stop alone -> busy 0, count frozen, pwm_out 0, no timeout.
5. irq_en=0101, timeouts on ch0 and ch1 -> irq_status=0011, irq=1. irq_clr[0] asserted in the same cycle as a new ch0 timeout -> irq_status[0] stays 1. Clear both -> irq=0 one cycle after status clears.
6. rst pulsed one cycle before ch0 expiry -> no timeout, all outputs 0. All four channels started together with different reloads -> independent timeouts at the predicted cycles.
